// File: rtl/tlb_ctrl_pkg.sv
// Shared types and constants for the TLB maintenance-op sequencer.
package tlb_ctrl_pkg;

  // Must match the CP0 TLB index width (32-entry TLB).
  localparam int TLB_IDX_W = 5;

  // Index value reported to CP0 when a probe finds no matching entry.
  localparam logic [31:0] TLBP_MISS = 32'h8000_0000;

  typedef enum logic [1:0] {
    TLBOP_R  = 2'd0,
    TLBOP_WI = 2'd1,
    TLBOP_WR = 2'd2,
    TLBOP_P  = 2'd3
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_PR_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } tlb_state_e;

endpackage

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBR/TLBWI/TLBWR/TLBP: issues the TLB array command, then
// the single-cycle CP0 strobe, then a done pulse. Strobes and commands are
// suppressed on any cycle carrying flush, cp0_wr_en or reset so CP0 sees
// each update exactly once.
module tlb_op_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int TLB_IDX_BITS = TLB_IDX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [1:0]              req_op,
  output logic                    req_ready,
  output logic                    done,
  output logic                    busy,
  input  logic                    flush,
  input  logic                    cp0_wr_en,
  input  logic [31:0]             cp0_tlb_index_i,
  input  logic [31:0]             cp0_entryhi_i,
  input  logic [31:0]             cp0_entrylo0_i,
  input  logic [31:0]             cp0_entrylo1_i,
  input  logic [11:0]             cp0_pagemask_i,
  output logic                    cp0_tlbr_o,
  output logic                    cp0_tlbp_o,
  output logic                    cp0_tlb_random_o,
  output logic [31:0]             cp0_entryhi_o,
  output logic [31:0]             cp0_entrylo0_o,
  output logic [31:0]             cp0_entrylo1_o,
  output logic [11:0]             cp0_pagemask_o,
  output logic [31:0]             cp0_index_o,
  output logic                    tlb_rd_en,
  output logic                    tlb_wr_en,
  output logic                    tlb_probe_en,
  output logic [TLB_IDX_BITS-1:0] tlb_idx,
  output logic [31:0]             tlb_wr_entryhi,
  output logic [31:0]             tlb_wr_entrylo0,
  output logic [31:0]             tlb_wr_entrylo1,
  output logic [11:0]             tlb_wr_pagemask,
  input  logic [31:0]             tlb_rd_entryhi,
  input  logic [31:0]             tlb_rd_entrylo0,
  input  logic [31:0]             tlb_rd_entrylo1,
  input  logic [11:0]             tlb_rd_pagemask,
  input  logic                    tlb_probe_hit,
  input  logic [TLB_IDX_BITS-1:0] tlb_probe_idx
);

  tlb_state_e              r_state;
  tlb_state_e              w_next_state;
  tlb_op_e                 r_op;
  logic                    w_accept;
  logic [TLB_IDX_BITS-1:0] w_idx;
  logic                    w_unused_idx_hi;

  // Only the low index bits address the array; upper CP0 bits are ignored.
  assign w_idx           = cp0_tlb_index_i[TLB_IDX_BITS-1:0];
  assign w_unused_idx_hi = ^cp0_tlb_index_i[31:TLB_IDX_BITS];

  // CP0 Index encoding of a probe result: P bit set on miss, else the entry.
  function automatic logic [31:0] probe_index(input logic hit,
                                              input logic [TLB_IDX_BITS-1:0] idx);
    logic [31:0] v;
    if (hit) begin
      v = {{(32-TLB_IDX_BITS){1'b0}}, idx};
    end else begin
      v = TLBP_MISS;
    end
    return v;
  endfunction

  // State register and latched op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= TLBOP_R;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op <= tlb_op_e'(req_op);
      end
    end
  end

  // Next state, TLB commands, CP0 strobes and data; all zero unless active.
  always_comb begin
    w_next_state     = r_state;
    w_accept         = 1'b0;
    req_ready        = 1'b0;
    done             = 1'b0;
    busy             = 1'b0;
    cp0_tlbr_o       = 1'b0;
    cp0_tlbp_o       = 1'b0;
    cp0_tlb_random_o = 1'b0;
    cp0_entryhi_o    = 32'd0;
    cp0_entrylo0_o   = 32'd0;
    cp0_entrylo1_o   = 32'd0;
    cp0_pagemask_o   = 12'd0;
    cp0_index_o      = 32'd0;
    tlb_rd_en        = 1'b0;
    tlb_wr_en        = 1'b0;
    tlb_probe_en     = 1'b0;
    tlb_idx          = '0;
    tlb_wr_entryhi   = 32'd0;
    tlb_wr_entrylo0  = 32'd0;
    tlb_wr_entrylo1  = 32'd0;
    tlb_wr_pagemask  = 12'd0;
    if (reset) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          req_ready = !flush;
          if (req_valid && !flush) begin
            w_accept     = 1'b1;
            w_next_state = ST_ISSUE;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          busy = 1'b1;
          if (flush) begin
            w_next_state = ST_IDLE;
          end else if (cp0_wr_en) begin
            w_next_state = ST_ISSUE;
          end else begin
            case (r_op)
              TLBOP_R: begin
                tlb_rd_en    = 1'b1;
                tlb_idx      = w_idx;
                w_next_state = ST_RD_WAIT;
              end
              TLBOP_P: begin
                tlb_probe_en = 1'b1;
                w_next_state = ST_PR_WAIT;
              end
              TLBOP_WI, TLBOP_WR: begin
                // Random is sampled before CP0 advances it on this strobe.
                cp0_tlb_random_o = (r_op == TLBOP_WR);
                tlb_wr_en        = 1'b1;
                tlb_idx          = w_idx;
                tlb_wr_entryhi   = cp0_entryhi_i;
                tlb_wr_entrylo0  = cp0_entrylo0_i;
                tlb_wr_entrylo1  = cp0_entrylo1_i;
                tlb_wr_pagemask  = cp0_pagemask_i;
                w_next_state     = ST_DONE;
              end
              default: begin
                w_next_state = ST_IDLE;
              end
            endcase
          end
        end
        ST_RD_WAIT: begin
          busy = 1'b1;
          if (flush) begin
            w_next_state = ST_IDLE;
          end else if (cp0_wr_en) begin
            w_next_state = ST_RD_WAIT;
          end else begin
            cp0_tlbr_o     = 1'b1;
            cp0_entryhi_o  = tlb_rd_entryhi;
            cp0_entrylo0_o = tlb_rd_entrylo0;
            cp0_entrylo1_o = tlb_rd_entrylo1;
            cp0_pagemask_o = tlb_rd_pagemask;
            w_next_state   = ST_DONE;
          end
        end
        ST_PR_WAIT: begin
          busy = 1'b1;
          if (flush) begin
            w_next_state = ST_IDLE;
          end else if (cp0_wr_en) begin
            w_next_state = ST_PR_WAIT;
          end else begin
            cp0_tlbp_o   = 1'b1;
            cp0_index_o  = probe_index(tlb_probe_hit, tlb_probe_idx);
            w_next_state = ST_DONE;
          end
        end
        ST_DONE: begin
          // The side effect is already committed, so flush cannot cancel it.
          busy         = 1'b1;
          done         = 1'b1;
          w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: the stimulus process predicts every
// observable event (accept, array command, CP0 strobe, done) with its cycle
// stamp; the monitor pops and compares whenever the DUT shows one.
module tb_tlb_op_ctrl;

  localparam int OP_R = 0, OP_WI = 1, OP_WR = 2, OP_P = 3;

  typedef struct packed {
    int unsigned cyc;
    logic        acc, rdy, busy, done, rd, wr, pr, tlbr, tlbp, rnd;
    logic [4:0]  idx;
    logic [31:0] index_o, ehi, lo0, lo1;
    logic [11:0] pm;
    logic [31:0] wehi, wlo0, wlo1;
    logic [11:0] wpm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, req_valid = 1'b0, flush = 1'b0, cp0_wr_en = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] cp0_tlb_index_i = 32'd0, cp0_entryhi_i = 32'd0;
  logic [31:0] cp0_entrylo0_i = 32'd0, cp0_entrylo1_i = 32'd0;
  logic [11:0] cp0_pagemask_i = 12'd0;
  logic        req_ready, done, busy, cp0_tlbr_o, cp0_tlbp_o, cp0_tlb_random_o;
  logic [31:0] cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o, cp0_index_o;
  logic [11:0] cp0_pagemask_o, tlb_wr_pagemask;
  logic        tlb_rd_en, tlb_wr_en, tlb_probe_en;
  logic [4:0]  tlb_idx;
  logic [31:0] tlb_wr_entryhi, tlb_wr_entrylo0, tlb_wr_entrylo1;
  logic [31:0] rd_ehi = 32'd0, rd_lo0 = 32'd0, rd_lo1 = 32'd0;
  logic [11:0] rd_pm = 12'd0;
  logic        probe_hit = 1'b0;
  logic [4:0]  probe_idx = 5'd0;

  tlb_op_ctrl #(.TLB_IDX_BITS(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .done(done), .busy(busy), .flush(flush),
    .cp0_wr_en(cp0_wr_en), .cp0_tlb_index_i(cp0_tlb_index_i),
    .cp0_entryhi_i(cp0_entryhi_i), .cp0_entrylo0_i(cp0_entrylo0_i),
    .cp0_entrylo1_i(cp0_entrylo1_i), .cp0_pagemask_i(cp0_pagemask_i),
    .cp0_tlbr_o(cp0_tlbr_o), .cp0_tlbp_o(cp0_tlbp_o),
    .cp0_tlb_random_o(cp0_tlb_random_o), .cp0_entryhi_o(cp0_entryhi_o),
    .cp0_entrylo0_o(cp0_entrylo0_o), .cp0_entrylo1_o(cp0_entrylo1_o),
    .cp0_pagemask_o(cp0_pagemask_o), .cp0_index_o(cp0_index_o),
    .tlb_rd_en(tlb_rd_en), .tlb_wr_en(tlb_wr_en), .tlb_probe_en(tlb_probe_en),
    .tlb_idx(tlb_idx), .tlb_wr_entryhi(tlb_wr_entryhi),
    .tlb_wr_entrylo0(tlb_wr_entrylo0), .tlb_wr_entrylo1(tlb_wr_entrylo1),
    .tlb_wr_pagemask(tlb_wr_pagemask), .tlb_rd_entryhi(rd_ehi),
    .tlb_rd_entrylo0(rd_lo0), .tlb_rd_entrylo1(rd_lo1),
    .tlb_rd_pagemask(rd_pm), .tlb_probe_hit(probe_hit),
    .tlb_probe_idx(probe_idx)
  );

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        snap = 1'b0;
  logic        end_chk = 1'b0;
  logic        mem_load = 1'b1;
  exp_t        q[$];

  // Environment TLB array (driven by DUT commands) and reference copy.
  logic [31:0] mem_ehi[32], mem_lo0[32], mem_lo1[32];
  logic [11:0] mem_pm[32];
  logic [31:0] ref_ehi[32], ref_lo0[32], ref_lo1[32];
  logic [11:0] ref_pm[32];

  function automatic logic [31:0] init_ehi(input int i);
    return 32'h1000_0000 | (32'(i) << 13);
  endfunction
  function automatic logic [31:0] init_lo0(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // Lowest matching index wins, the array's documented priority.
  function automatic logic [5:0] env_probe(input logic [31:0] key);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 31; i >= 0; i--) if (mem_ehi[i] == key) r = {1'b1, 5'(i)};
    return r;
  endfunction
  function automatic logic [5:0] ref_probe(input logic [31:0] key);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 31; i >= 0; i--) if (ref_ehi[i] == key) r = {1'b1, 5'(i)};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // TLB array behaviour: read/probe results appear next cycle and are held.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) begin
        mem_ehi[i] <= init_ehi(i);
        mem_lo0[i] <= init_lo0(i);
        mem_lo1[i] <= ~init_lo0(i);
        mem_pm[i]  <= 12'(i * 37);
      end
    end else begin
      if (tlb_wr_en) begin
        mem_ehi[tlb_idx] <= tlb_wr_entryhi;
        mem_lo0[tlb_idx] <= tlb_wr_entrylo0;
        mem_lo1[tlb_idx] <= tlb_wr_entrylo1;
        mem_pm[tlb_idx]  <= tlb_wr_pagemask;
      end
      if (tlb_rd_en) begin
        rd_ehi <= mem_ehi[tlb_idx];
        rd_lo0 <= mem_lo0[tlb_idx];
        rd_lo1 <= mem_lo1[tlb_idx];
        rd_pm  <= mem_pm[tlb_idx];
      end
      if (tlb_probe_en) {probe_hit, probe_idx} <= env_probe(cp0_entryhi_i);
    end
  end

  // Monitor: compare every observed event (or requested snapshot) in order.
  always @(negedge clk) begin
    exp_t act, e;
    act = '0;
    act.cyc = cyc;
    act.acc = req_valid && req_ready;  act.rdy = req_ready;  act.busy = busy;
    act.done = done;  act.rd = tlb_rd_en;  act.wr = tlb_wr_en;
    act.pr = tlb_probe_en;  act.tlbr = cp0_tlbr_o;  act.tlbp = cp0_tlbp_o;
    act.rnd = cp0_tlb_random_o;  act.idx = tlb_idx;  act.index_o = cp0_index_o;
    act.ehi = cp0_entryhi_o;  act.lo0 = cp0_entrylo0_o;
    act.lo1 = cp0_entrylo1_o;  act.pm = cp0_pagemask_o;
    act.wehi = tlb_wr_entryhi;  act.wlo0 = tlb_wr_entrylo0;
    act.wlo1 = tlb_wr_entrylo1;  act.wpm = tlb_wr_pagemask;
    if (snap || act.acc || act.done || act.rd || act.wr || act.pr ||
        act.tlbr || act.tlbp || act.rnd) begin
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_event cyc=%0d got=%h want=none", cyc, act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors = errors + 1;
          $display("FAIL event cyc=%0d got=%h want=%h", cyc, act, e);
        end
      end
    end
    if (end_chk) begin
      checks = checks + 1;
      if (q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL missing_events got=%0d want=0 pending", q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.cyc = cyc;
    return e;
  endfunction

  // One op with s_iss mtc0 stalls in ISSUE, s_wait in the wait state.
  // fl: 0 = flush in ISSUE, 1 = flush in the wait state, other = none.
  task automatic run_op(input int op, input logic [31:0] idx_in,
                        input int s_iss, input int s_wait, input int fl);
    exp_t e;
    logic [5:0] pr;
    logic [4:0] ix;
    ix = idx_in[4:0];
    req_valid = 1'b1;  req_op = 2'(op);  flush = 1'b0;  cp0_wr_en = 1'b0;
    cp0_tlb_index_i = idx_in;
    e = blank();  e.acc = 1'b1;  e.rdy = 1'b1;  q.push_back(e);
    tick();
    req_valid = 1'b0;  req_op = 2'($urandom);
    for (int k = 0; k < s_iss; k++) begin cp0_wr_en = 1'b1; tick(); end
    cp0_wr_en = 1'b0;
    if (fl == 0) begin
      flush = 1'b1;  snap = 1'b1;
      e = blank();  e.busy = 1'b1;  q.push_back(e);
      tick();
      flush = 1'b0;  snap = 1'b0;
      return;
    end
    e = blank();  e.busy = 1'b1;
    if (op == OP_R) begin
      e.rd = 1'b1;  e.idx = ix;
    end else if (op == OP_P) begin
      e.pr = 1'b1;
    end else begin
      e.wr = 1'b1;  e.rnd = (op == OP_WR);  e.idx = ix;
      e.wehi = cp0_entryhi_i;  e.wlo0 = cp0_entrylo0_i;
      e.wlo1 = cp0_entrylo1_i;  e.wpm = cp0_pagemask_i;
      ref_ehi[ix] = cp0_entryhi_i;  ref_lo0[ix] = cp0_entrylo0_i;
      ref_lo1[ix] = cp0_entrylo1_i;  ref_pm[ix] = cp0_pagemask_i;
    end
    q.push_back(e);
    tick();
    if (op == OP_R || op == OP_P) begin
      for (int k = 0; k < s_wait; k++) begin cp0_wr_en = 1'b1; tick(); end
      cp0_wr_en = 1'b0;
      if (fl == 1) begin
        flush = 1'b1;  snap = 1'b1;
        e = blank();  e.busy = 1'b1;  q.push_back(e);
        tick();
        flush = 1'b0;  snap = 1'b0;
        return;
      end
      e = blank();  e.busy = 1'b1;
      if (op == OP_R) begin
        e.tlbr = 1'b1;  e.ehi = ref_ehi[ix];  e.lo0 = ref_lo0[ix];
        e.lo1 = ref_lo1[ix];  e.pm = ref_pm[ix];
      end else begin
        pr = ref_probe(cp0_entryhi_i);
        e.tlbp = 1'b1;
        e.index_o = pr[5] ? {27'd0, pr[4:0]} : 32'h8000_0000;
      end
      q.push_back(e);
      tick();
    end
    // done cannot be cancelled, so disturb it with random flush/mtc0
    flush = 1'($urandom);  cp0_wr_en = 1'($urandom);
    e = blank();  e.busy = 1'b1;  e.done = 1'b1;  q.push_back(e);
    tick();
    flush = 1'b0;  cp0_wr_en = 1'b0;
  endtask

  task automatic set_data(input logic [31:0] hi);
    cp0_entryhi_i = hi;  cp0_entrylo0_i = $urandom;  cp0_entrylo1_i = $urandom;
    cp0_pagemask_i = 12'($urandom);
  endtask

  initial begin
    exp_t e;
    int op, fl, gap;
    for (int i = 0; i < 32; i++) begin
      ref_ehi[i] = init_ehi(i);  ref_lo0[i] = init_lo0(i);
      ref_lo1[i] = ~init_lo0(i);  ref_pm[i] = 12'(i * 37);
    end
    repeat (3) tick();
    reset = 1'b0;  mem_load = 1'b0;  snap = 1'b1;
    e = blank();  e.rdy = 1'b1;  q.push_back(e);
    tick();
    snap = 1'b0;

    // TLBWI at Index 7
    set_data(32'h1234_6000);
    run_op(OP_WI, 32'd7, 0, 0, -1);
    // TLBWR at Random 31, then at the wrapped value 4
    set_data(32'h2222_2000);
    run_op(OP_WR, 32'd31, 0, 0, -1);
    set_data(32'h3333_3000);
    run_op(OP_WR, 32'd4, 0, 0, -1);
    // TLBP hit at 9, then a miss
    set_data(init_ehi(9));
    run_op(OP_P, 32'd0, 0, 0, -1);
    set_data(32'hFFFF_F000);
    run_op(OP_P, 32'd0, 0, 1, -1);
    // TLBR at 3 with two mtc0 stall cycles in RD_WAIT
    run_op(OP_R, 32'd3, 0, 2, -1);
    // flush in ISSUE, then flush in PR_WAIT
    set_data(32'h4444_4000);
    run_op(OP_WI, 32'd12, 1, 0, 0);
    set_data(init_ehi(5));
    run_op(OP_P, 32'd0, 0, 1, 1);
    // request while flush is high in IDLE is refused
    req_valid = 1'b1;  flush = 1'b1;  snap = 1'b1;
    e = blank();  q.push_back(e);
    tick();
    req_valid = 1'b0;  flush = 1'b0;  snap = 1'b0;
    // reset while in RD_WAIT: no strobe, IDLE and ready next cycle
    cp0_tlb_index_i = 32'd3;  req_valid = 1'b1;  req_op = 2'd0;
    e = blank();  e.acc = 1'b1;  e.rdy = 1'b1;  q.push_back(e);
    tick();
    req_valid = 1'b0;
    e = blank();  e.busy = 1'b1;  e.rd = 1'b1;  e.idx = 5'd3;  q.push_back(e);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;  snap = 1'b1;
    e = blank();  e.rdy = 1'b1;  q.push_back(e);
    tick();
    snap = 1'b0;

    // randomized ops
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 3));
      if (op == OP_P && $urandom_range(0, 1) == 1)
        set_data(ref_ehi[$urandom_range(0, 31)]);
      else
        set_data($urandom);
      fl = int'($urandom_range(0, 9));
      if (fl == 1 && !(op == OP_R || op == OP_P)) fl = 5;
      run_op(op, $urandom, int'($urandom_range(0, 3)) / 2,
             int'($urandom_range(0, 3)) / 2, fl);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 2) == 0) begin
          req_valid = 1'b1;  flush = 1'b1;  snap = 1'b1;
          e = blank();  q.push_back(e);
        end
        tick();
        req_valid = 1'b0;  flush = 1'b0;  snap = 1'b0;
      end
    end

    repeat (3) tick();
    end_chk = 1'b1;
    tick();
    end_chk = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the TLB maintenance instructions (TLBR, TLBWI, TLBWR, TLBP) between the memory stage, the TLB array and CP0. It accepts one op at a time from the pipeline and issues the TLB array read, write or probe. It then delivers the single-cycle CP0 strobes (tlbr, tlbp, TLB_random) and the result data so that CP0's Index, Random, EntryHi, EntryLo0/1 and PageMask update exactly once. It stalls across mtc0 writes and aborts cleanly on exception flush.

## Interface
- TLB_IDX_BITS, 5, TLB index width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  TLB op request from memory stage
- req_op  in  2  0 TLBR, 1 TLBWI, 2 TLBWR, 3 TLBP
- req_ready  out  1  controller can accept an op
- done  out  1  one-cycle pulse: op retired
- busy  out  1  FSM not IDLE
- flush  in  1  CP0 exception/interrupt request this cycle
- cp0_wr_en  in  1  mtc0 to CP0 this cycle
- cp0_tlb_index_i  in  32  CP0 TLB index (Random when cp0_tlb_random_o=1, else Index)
- cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i  in  32 each  CP0 register values
- cp0_pagemask_i  in  12  CP0 PageMask[24:13]
- cp0_tlbr_o, cp0_tlbp_o, cp0_tlb_random_o  out  1 each  CP0 strobes
- cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o  out  32 each  TLBR data to CP0
- cp0_pagemask_o  out  12  TLBR PageMask to CP0
- cp0_index_o  out  32  TLBP result to CP0
- tlb_rd_en, tlb_wr_en, tlb_probe_en  out  1 each  TLB array commands
- tlb_idx  out  TLB_IDX_BITS  index for read/write
- tlb_rd_entryhi, tlb_rd_entrylo0, tlb_rd_entrylo1  in  32 each  read data, valid the cycle after tlb_rd_en, held until next tlb_rd_en
- tlb_rd_pagemask  in  12  same timing
- tlb_probe_hit  in  1, tlb_probe_idx  in  TLB_IDX_BITS  probe result, valid the cycle after tlb_probe_en, held until next tlb_probe_en

## Operation
- States: IDLE, ISSUE, RD_WAIT, PR_WAIT, DONE.
- IDLE:
  - req_ready = !flush.
  - req_valid && !flush: latch req_op, go to ISSUE.
- ISSUE:
  - flush: go to IDLE with no TLB command.
  - else cp0_wr_en: hold; no command.
  - else by op:
    - TLBR: tlb_rd_en=1, tlb_idx=cp0_tlb_index_i[TLB_IDX_BITS-1:0], go to RD_WAIT.
    - TLBP: tlb_probe_en=1, go to PR_WAIT. The array compares cp0_entryhi_i.
    - TLBWI: tlb_wr_en=1, tlb_idx from Index, go to DONE.
    - TLBWR: cp0_tlb_random_o=1 and tlb_wr_en=1 in the same cycle, tlb_idx=cp0_tlb_index_i (pre-advance Random), go to DONE. CP0 advances Random on this strobe.
- Write data to the array is cp0_entryhi_i/lo0/lo1/pagemask_i, passed straight through.
- RD_WAIT:
  - flush: go to IDLE, no strobe.
  - cp0_wr_en: hold.
  - else cp0_tlbr_o=1, data outputs = tlb_rd_*, go to DONE.
- PR_WAIT:
  - flush: go to IDLE.
  - cp0_wr_en: hold.
  - else cp0_tlbp_o=1. cp0_index_o = hit ? zero-extended tlb_probe_idx : 32'h8000_0000. Go to DONE.
- DONE: done=1 unconditionally (side effect already committed), go to IDLE.
- Strobes are never asserted in a cycle with flush or cp0_wr_en, because CP0 gives Req and en priority over tlbr/tlbp/TLB_random.
- At most one of the three CP0 strobes is high in any cycle; each is high for exactly one cycle per op.

## Timing
- Reset: state IDLE, latched op 0. After reset deassertion req_ready=1 (with flush=0). All other outputs 0, including done, busy and all strobes.
- Reset mid-op returns to IDLE next cycle, with no strobe or command issued.
- Latency without stalls, accept at cycle 0:
  - TLBWI/TLBWR: write at cycle 1, done at cycle 2.
  - TLBR/TLBP: array command at cycle 1, CP0 strobe at cycle 2, done at cycle 3.
- Each cycle of cp0_wr_en in ISSUE, RD_WAIT or PR_WAIT adds one cycle.
- No back-to-back acceptance: the next op can be accepted in the cycle after done.
- Data outputs are combinational from array data in the strobe cycle and 0 otherwise.

## Structure
- Shared package tlb_ctrl_pkg holds:
  - op enum: TLBOP_R, TLBOP_WI, TLBOP_WR, TLBOP_P.
  - FSM state enum.
  - TLBP_MISS constant 32'h8000_0000.
- TLB_IDX_BITS stays consistent with the CP0 TLB index width (5).
- Single module; no sub-module warranted.

## Test plan
- TLBWI with Index=7, EntryHi=0x1234_6000: tlb_wr_en at cycle 1 with tlb_idx=7, done at cycle 2, no CP0 strobe.
- TLBWR with Random=31, Wired=4: cp0_tlb_random_o and tlb_wr_en together, tlb_idx=31 for exactly one cycle. A second TLBWR writes idx 4, because CP0 wraps Random to Wired.
- TLBP hit at idx 9 gives cp0_tlbp_o with cp0_index_o=0x0000_0009. A miss gives 0x8000_0000. done follows one cycle later.
- TLBR at Index=3 with cp0_wr_en held 2 cycles in RD_WAIT: cp0_tlbr_o delayed 2 cycles and carries entry 3 data; done at cycle 5.
- flush asserted in ISSUE, then separately in PR_WAIT: no tlb command (ISSUE case) and no CP0 strobe (both cases), no done, req_ready=1 next cycle.
- reset asserted in RD_WAIT: next cycle state IDLE, all strobes 0, busy=0.
